// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register pending scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*AW-1:0]     waddr,
    input  logic [NUM_WR*XLEN-1:0]   wdata,
    input  logic [NUM_RD*AW-1:0]     raddr,
    output logic [NUM_RD*XLEN-1:0]   rdata,
    output logic [NUM_RD-1:0]        rready,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic                     rsv_busy,
    output logic [NREGS-1:0]         pending
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             rsv_ok_s;

    assign rsv_ok_s = rsv_en && (rsv_addr != {AW{1'b0}});

    // Next-state: ascending port order lets the highest-index write win; reserve applied last.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (we[k] && (waddr[k*AW +: AW] != {AW{1'b0}})) begin
                regs_d[waddr[k*AW +: AW]]    = wdata[k*XLEN +: XLEN];
                pending_d[waddr[k*AW +: AW]] = 1'b0;
            end else begin
                pending_d = pending_d;
            end
        end
        if (rsv_ok_s) begin
            pending_d[rsv_addr] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            pending_q <= {NREGS{1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q <= pending_d;
        end
    end

    // Combinational read ports; x0 always reads as a ready zero.
    always_comb begin
        rdata  = {(NUM_RD*XLEN){1'b0}};
        rready = {NUM_RD{1'b0}};
        for (int j = 0; j < NUM_RD; j++) begin
            if (raddr[j*AW +: AW] == {AW{1'b0}}) begin
                rdata[j*XLEN +: XLEN] = {XLEN{1'b0}};
                rready[j]             = 1'b1;
            end else begin
                rdata[j*XLEN +: XLEN] = regs_q[raddr[j*AW +: AW]];
                rready[j]             = ~pending_q[raddr[j*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NUM_WR; k++) begin
                    if (we[k] && (waddr[k*AW +: AW] == raddr[j*AW +: AW])) begin
                        rdata[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
                        rready[j]             = ~(rsv_en && (rsv_addr == raddr[j*AW +: AW]));
                    end else begin
                        rready[j] = rready[j];
                    end
                end
`else
                rready[j] = rready[j];
`endif
            end
        end
    end

    assign rsv_busy = rsv_ok_s && pending_q[rsv_addr];
    assign pending  = pending_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized self-checking bench for regfile_mp_sb against an array-based reference model.
// Honours REGFILE_BYPASS_EN the same way as the design build.
module tb_regfile_mp_sb;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_WR-1:0]      we;
    logic [NUM_WR*AW-1:0]   waddr;
    logic [NUM_WR*XLEN-1:0] wdata;
    logic [NUM_RD*AW-1:0]   raddr;
    logic [NUM_RD*XLEN-1:0] rdata;
    logic [NUM_RD-1:0]      rready;
    logic                   rsv_en;
    logic [AW-1:0]          rsv_addr;
    logic                   rsv_busy;
    logic [NREGS-1:0]       pending;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rready(rready),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_busy(rsv_busy), .pending(pending)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_regs [NREGS];
    bit          m_pend [NREGS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0; raddr = '0; rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic set_wr(input int k, input int a, input logic [31:0] d);
        we[k] = 1'b1;
        waddr[k*AW +: AW] = AW'(a);
        wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int j, input int a);
        raddr[j*AW +: AW] = AW'(a);
    endtask

    // Compare every output against the model for the current inputs.
    task automatic compare();
        logic [NREGS-1:0] exp_pend;
        for (int j = 0; j < NUM_RD; j++) begin
            int          a;
            logic [31:0] ed;
            logic        er;
            a = int'(raddr[j*AW +: AW]);
            if (a == 0) begin
                ed = 32'h0; er = 1'b1;
            end else begin
                ed = m_regs[a]; er = !m_pend[a];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NUM_WR; k++)
                    if (we[k] && int'(waddr[k*AW +: AW]) == a) begin
                        ed = wdata[k*XLEN +: XLEN];
                        er = !(rsv_en && int'(rsv_addr) == a);
                    end
`endif
            end
            chk($sformatf("rdata%0d", j), 64'(rdata[j*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("rready%0d", j), 64'(rready[j]), 64'(er));
        end
        for (int i = 0; i < NREGS; i++) exp_pend[i] = m_pend[i];
        chk("pending", 64'(pending), 64'(exp_pend));
        chk("rsv_busy", 64'(rsv_busy), 64'(rsv_en && rsv_addr != 0 && m_pend[rsv_addr]));
    endtask

    task automatic model_update();
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin m_regs[i] = 32'h0; m_pend[i] = 1'b0; end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                int a;
                a = int'(waddr[k*AW +: AW]);
                if (we[k] && a != 0) begin m_regs[a] = wdata[k*XLEN +: XLEN]; m_pend[a] = 1'b0; end
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
    endtask

    // Inputs are driven at the falling edge; outputs checked 1 time unit later.
    task automatic step();
        #1 compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk); model_update(); @(negedge clk);
        rst_n = 1'b1;

        // Reset beats preloaded state and same-cycle write/reserve.
        set_wr(0, 4, 32'h55); set_wr(1, 6, 32'h66); rsv_en = 1'b1; rsv_addr = 5'd8; step();
        idle(); rst_n = 1'b0; set_wr(0, 4, 32'h77); rsv_en = 1'b1; rsv_addr = 5'd4; step();
        rst_n = 1'b1; idle(); set_rd(0, 4); set_rd(1, 6);
        #1 chk("rst_rdata0", 64'(rdata[31:0]), 64'h0);
        chk("rst_rdata1", 64'(rdata[63:32]), 64'h0);
        chk("rst_pending", 64'(pending), 64'h0);
        chk("rst_rready", 64'(rready), 64'h3);
        step();

        // x0 writes and reserves are dropped.
        set_wr(0, 0, 32'hDEADBEEF); rsv_en = 1'b1; rsv_addr = 5'd0; set_rd(0, 0);
        #1 chk("x0_busy", 64'(rsv_busy), 64'h0);
        step();
        idle(); set_rd(0, 0);
        #1 chk("x0_rdata", 64'(rdata[31:0]), 64'h0);
        chk("x0_pend", 64'(pending[0]), 64'h0);
        step();

        // Scoreboard reserve / busy / clear.
        rsv_en = 1'b1; rsv_addr = 5'd5; step();
        idle(); set_rd(0, 5);
        #1 chk("sb_rready", 64'(rready[0]), 64'h0);
        chk("sb_pend5", 64'(pending[5]), 64'h1);
        rsv_en = 1'b1; rsv_addr = 5'd5;
        #1 chk("sb_busy", 64'(rsv_busy), 64'h1);
        step();
        idle(); set_wr(0, 5, 32'h1234); step();
        idle(); set_rd(1, 5);
        #1 chk("sb_data", 64'(rdata[63:32]), 64'h1234);
        chk("sb_ready", 64'(rready[1]), 64'h1);
        step();

        // Reserve and write to the same register in one cycle.
        idle(); rsv_en = 1'b1; rsv_addr = 5'd7; set_wr(1, 7, 32'hA5A5); step();
        idle(); set_rd(0, 7);
        #1 chk("rw_data", 64'(rdata[31:0]), 64'hA5A5);
        chk("rw_pend7", 64'(pending[7]), 64'h1);
        step();

        // Same-address multi-write: port 1 wins; distinct addresses both land.
        idle(); set_wr(0, 9, 32'h1); set_wr(1, 9, 32'h2); step();
        idle(); set_wr(0, 10, 32'hA); set_wr(1, 11, 32'hB); set_rd(0, 9); step();
        idle(); set_rd(0, 10); set_rd(1, 11);
        #1 chk("mw_r10", 64'(rdata[31:0]), 64'hA);
        chk("mw_r11", 64'(rdata[63:32]), 64'hB);
        step();
        idle(); set_rd(0, 9);
        #1 chk("mw_r9", 64'(rdata[31:0]), 64'h2);
        step();

        // Write-to-read latency.
        idle(); set_wr(0, 3, 32'h1111); step();
        idle(); set_wr(0, 3, 32'hCAFE); set_rd(0, 3);
`ifdef REGFILE_BYPASS_EN
        #1 chk("byp_same", 64'(rdata[31:0]), 64'hCAFE);
`else
        #1 chk("byp_same", 64'(rdata[31:0]), 64'h1111);
`endif
        step();
        idle(); set_rd(0, 3);
        #1 chk("byp_next", 64'(rdata[31:0]), 64'hCAFE);
        step();

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            idle();
            rst_n = ($urandom_range(0, 59) != 0);
            for (int k = 0; k < NUM_WR; k++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7), $urandom);
            for (int j = 0; j < NUM_RD; j++)
                set_rd(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            rsv_en = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
